// File: rtl/host_mailbox.sv
// Test-host mailbox on the core data bus: cycle counter, console byte FIFO and
// a sticky test-done/exit-code register in a 16-byte window.
module host_mailbox #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 'h3FFFF0,
  parameter int unsigned            FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  sel_o,
  output logic                  cons_valid_o,
  output logic [7:0]            cons_data_o,
  input  logic                  cons_ready_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [30:0]           exit_code_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    OFF_CYCLE   = 2'd0,
    OFF_STATUS  = 2'd1,
    OFF_CONSOLE = 2'd2,
    OFF_TOHOST  = 2'd3
  } offset_e;

  offset_e        offset;
  logic           hit;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           tohost_ok;
  logic [31:0]    status;
  logic           unused_addr;

  logic [31:0]    cycle_q,  cycle_d;
  logic           rvalid_q, rvalid_d;
  logic [31:0]    rdata_q,  rdata_d;
  logic           done_q,   done_d;
  logic           pass_q,   pass_d;
  logic [30:0]    exit_q,   exit_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q,  count_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];

  assign unused_addr = ^data_addr_i[1:0];

  always_comb begin
    offset = offset_e'(data_addr_i[3:2]);
    hit    = data_req_i & (data_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    full   = (count_q == CW'(FIFO_DEPTH));
    empty  = (count_q == '0);

    sel_o      = hit;
    // A full FIFO stalls console writes even if a pop frees a slot this cycle.
    data_gnt_o = hit & ~(data_we_i & (offset == OFF_CONSOLE) & full);

    push      = data_gnt_o & data_we_i & (offset == OFF_CONSOLE) & data_be_i[0];
    pop       = ~empty & cons_ready_i;
    tohost_ok = data_gnt_o & data_we_i & (offset == OFF_TOHOST) &
                (data_be_i == 4'hF) & data_wdata_i[0] & ~done_q;

    status           = '0;
    status[31]       = done_q;
    status[30]       = full;
    status[CW-1:0]   = count_q;

    cycle_d  = cycle_q + 32'd1;
    rvalid_d = data_gnt_o;
    rdata_d  = '0;
    if (data_gnt_o && !data_we_i) begin
      unique case (offset)
        OFF_CYCLE:  rdata_d = cycle_q;
        OFF_STATUS: rdata_d = status;
        default:    rdata_d = '0;
      endcase
    end

    done_d = done_q;
    pass_d = pass_q;
    exit_d = exit_q;
    if (tohost_ok) begin
      done_d = 1'b1;
      exit_d = data_wdata_i[31:1];
      pass_d = (data_wdata_i[31:1] == '0);
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_wdata_i[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cycle_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      exit_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cycle_q  <= cycle_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      exit_q   <= exit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign cons_valid_o  = ~empty;
  assign cons_data_o   = empty ? '0 : mem_q[rd_ptr_q];
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign exit_code_o   = exit_q;

endmodule

// File: tb/tb_host_mailbox.sv
// Directed self-checking bench for host_mailbox with hand-computed expectations.
module tb_host_mailbox;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        sel;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic        done;
  logic        pass;
  logic [30:0] exit_code;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [31:0] A_CYCLE   = 32'h003F_FFF0;
  localparam logic [31:0] A_STATUS  = 32'h003F_FFF4;
  localparam logic [31:0] A_CONSOLE = 32'h003F_FFF8;
  localparam logic [31:0] A_TOHOST  = 32'h003F_FFFC;

  host_mailbox #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h003F_FFF0),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .data_req_i    (req),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_gnt_o    (gnt),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .sel_o         (sel),
    .cons_valid_o  (cons_valid),
    .cons_data_o   (cons_data),
    .cons_ready_i  (cons_ready),
    .done_o        (done),
    .pass_o        (pass),
    .exit_code_o   (exit_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus transaction; waits (bounded) for grant, returns the response data.
  task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] b,
                     input logic [31:0] wd, output logic [31:0] rd);
    int unsigned n = 0;
    req = 1'b1; addr = a; we = w; be = b; wdata = wd;
    #1;
    while (!gnt && n < 20) begin
      step();
      n++;
    end
    check("gnt", {31'b0, gnt}, 32'd1);
    step();
    req = 1'b0;
    check("rvalid", {31'b0, rvalid}, 32'd1);
    rd = rdata;
  endtask

  initial begin
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] rd;

    rstn = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; cons_ready = 1'b0;
    repeat (3) step();
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_cons_valid", {31'b0, cons_valid}, 32'd0);
    check("rst_cons_data", {24'b0, cons_data}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_pass", {31'b0, pass}, 32'd0);
    check("rst_exit", {1'b0, exit_code}, 32'd0);
    rstn = 1'b1;
    step();

    // Cycle counter: grants 5 cycles apart differ by 5
    bus(A_CYCLE, 1'b0, 4'hF, '0, v1);
    repeat (4) @(posedge clk);
    #1;
    bus(A_CYCLE, 1'b0, 4'hF, '0, v2);
    check("cycle_delta", v2 - v1, 32'd5);
    step();
    check("rdata_idle_zero", rdata, 32'd0);
    check("rvalid_idle", {31'b0, rvalid}, 32'd0);

    // Miss outside the window
    req = 1'b1; addr = 32'h003F_FFE0; we = 1'b0; #1;
    check("miss_sel", {31'b0, sel}, 32'd0);
    check("miss_gnt", {31'b0, gnt}, 32'd0);
    step();
    req = 1'b0;
    check("miss_rvalid", {31'b0, rvalid}, 32'd0);

    // Console pass-through with sink ready
    cons_ready = 1'b1;
    bus(A_CONSOLE, 1'b1, 4'h1, 32'h0000_0048, rd);
    check("write_rdata_zero", rd, 32'd0);
    check("cons_h", {24'b0, cons_data}, 32'h48);
    bus(A_CONSOLE, 1'b1, 4'h1, 32'h0000_0069, rd);
    check("cons_i", {24'b0, cons_data}, 32'h69);
    step();
    check("cons_drained", {31'b0, cons_valid}, 32'd0);
    bus(A_STATUS, 1'b0, 4'hF, '0, rd);
    check("status_empty", rd, 32'h0000_0000);
    bus(A_CONSOLE, 1'b1, 4'h0, 32'h0000_00AA, rd);
    check("be0_no_push", {31'b0, cons_valid}, 32'd0);
    bus(A_CONSOLE, 1'b0, 4'hF, '0, rd);
    check("wo_read_zero", rd, 32'd0);

    // Fill FIFO, stall the 9th write, release
    cons_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus(A_CONSOLE, 1'b1, 4'h1, 32'h10 + i, rd);
    bus(A_STATUS, 1'b0, 4'hF, '0, rd);
    check("status_full", rd, 32'h4000_0008);
    req = 1'b1; addr = A_CONSOLE; we = 1'b1; be = 4'h1; wdata = 32'h18; #1;
    check("full_gnt0", {31'b0, gnt}, 32'd0);
    step();
    check("full_no_rvalid", {31'b0, rvalid}, 32'd0);
    cons_ready = 1'b1; #1;
    check("full_pop_gnt0", {31'b0, gnt}, 32'd0);
    check("head_10", {24'b0, cons_data}, 32'h10);
    step();
    check("gnt_after_pop", {31'b0, gnt}, 32'd1);
    check("head_11", {24'b0, cons_data}, 32'h11);
    step();
    req = 1'b0;
    check("stall_rvalid", {31'b0, rvalid}, 32'd1);
    for (int i = 2; i <= 8; i++) begin
      check("drain_valid", {31'b0, cons_valid}, 32'd1);
      check("drain_data", {24'b0, cons_data}, 32'h10 + i);
      step();
    end
    check("drain_empty", {31'b0, cons_valid}, 32'd0);

    // TOHOST pass, then sticky
    bus(A_TOHOST, 1'b1, 4'hF, 32'h0000_0001, rd);
    check("done1", {31'b0, done}, 32'd1);
    check("pass1", {31'b0, pass}, 32'd1);
    check("exit0", {1'b0, exit_code}, 32'd0);
    bus(A_TOHOST, 1'b1, 4'hF, 32'h0000_000B, rd);
    check("sticky_pass", {31'b0, pass}, 32'd1);
    check("sticky_exit", {1'b0, exit_code}, 32'd0);
    bus(A_STATUS, 1'b0, 4'hF, '0, rd);
    check("status_done", rd, 32'h8000_0000);

    // Mid-operation reset with 3 bytes queued and a response pending
    cons_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(A_CONSOLE, 1'b1, 4'h1, 32'h30 + i, rd);
    req = 1'b1; addr = A_STATUS; we = 1'b0; be = 4'hF;
    @(posedge clk);
    #1;
    req = 1'b0;
    rstn = 1'b0;
    #1;
    check("rstmid_rvalid", {31'b0, rvalid}, 32'd0);
    check("rstmid_rdata", rdata, 32'd0);
    check("rstmid_cons_valid", {31'b0, cons_valid}, 32'd0);
    check("rstmid_done", {31'b0, done}, 32'd0);
    step();
    rstn = 1'b1;
    step();
    bus(A_STATUS, 1'b0, 4'hF, '0, rd);
    check("status_after_rst", rd, 32'd0);

    // Partial byte enables ignored, full word accepted with failing code
    bus(A_TOHOST, 1'b1, 4'h3, 32'h0000_000B, rd);
    check("be3_ignored", {31'b0, done}, 32'd0);
    bus(A_TOHOST, 1'b1, 4'hF, 32'h0000_000B, rd);
    check("done2", {31'b0, done}, 32'd1);
    check("exit5", {1'b0, exit_code}, 32'd5);
    check("pass0", {31'b0, pass}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/host_mailbox.md
Name: host_mailbox

Overview:
Memory-mapped test-host peripheral on the core data bus, alongside the data RAM, in the same address window as the finish address 0x3FFFFC. It decodes a 16-byte register window and provides:
- a console byte FIFO drained over a valid/ready stream;
- a sticky test-done/exit-code register;
- a free-running cycle counter.
Benches and FPGA builds observe done_o/pass_o instead of snooping raw bus signals.

Parameters:
BASE_ADDR, 'h3FFFF0, byte base of the 16-byte window; bits [3:0] must be 0
ADDR_WIDTH, 32, data bus address width
FIFO_DEPTH, 8, console FIFO entries; power of 2, >=2

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
data_req_i  in  1  bus request
data_addr_i  in  ADDR_WIDTH  byte address
data_we_i  in  1  1=write, 0=read
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_gnt_o  out  1  grant, combinational
data_rvalid_o  out  1  response valid, registered
data_rdata_o  out  32  read data
sel_o  out  1  address hit, combinational, for external response mux
cons_valid_o  out  1  console byte available
cons_data_o  out  8  console byte (FIFO head)
cons_ready_i  in  1  console sink accepts byte
done_o  out  1  test finished, sticky
pass_o  out  1  done_o and exit code == 0
exit_code_o  out  31  exit code written by software

Behaviour:
- Reset values: data_rvalid_o=0, data_rdata_o=0, cons_valid_o=0, cons_data_o=0, done_o=0, pass_o=0, exit_code_o=0, cycle counter=0, FIFO empty.
- Decode: sel_o = data_req_i & (data_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]); offset = data_addr_i[3:2]. data_addr_i[1:0] is ignored.
- Register map:
  - 0x0 CYCLE, RO: 32-bit counter, +1 every cycle out of reset, wraps 0xFFFFFFFF->0.
  - 0x4 STATUS, RO: [31]=done, [30]=FIFO full, [15:0]=FIFO occupancy (zero-extended), other bits 0.
  - 0x8 CONSOLE, WO: push data_wdata_i[7:0] when data_be_i[0]=1; write with be[0]=0 is granted, no push.
  - 0xC TOHOST, WO: accepted only when data_be_i==4'hF and data_wdata_i[0]=1 and done_o=0. Then done_o<=1, exit_code_o<=data_wdata_i[31:1], pass_o<=(data_wdata_i[31:1]==0). Otherwise granted, no effect.
- Grant: data_gnt_o = sel_o & ~(we & offset==0x8 & FIFO full). Non-hit requests get gnt=0; the block does not respond to them.
- Response:
  - data_rvalid_o=1 exactly one cycle after each granted request (read or write); back-to-back grants give back-to-back rvalid.
  - data_rdata_o is registered with the grant: reads of RO registers return the value sampled in the grant cycle.
  - Writes and reads of WO offsets return 0.
  - data_rdata_o=0 whenever data_rvalid_o=0.
- Console FIFO:
  - Push on granted CONSOLE write with be[0]; pop when cons_valid_o & cons_ready_i.
  - cons_valid_o = ~empty; cons_data_o = head entry, 0 when empty.
  - Full: CONSOLE write is stalled (gnt=0, req held by master), even if a pop occurs in the same cycle; grant comes the following cycle.
  - Empty with push: no pop that cycle; byte becomes visible the next cycle (1-cycle latency).
  - Push and pop in the same cycle when neither full nor empty: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- done_o, exit_code_o and pass_o are sticky until reset; the first accepted TOHOST write wins.
- Reset asserted mid-operation clears all state immediately, including a pending rvalid and FIFO contents. No response is owed for a grant issued in the cycle reset asserts.

Test Plan:
- Reset release, then read 0x3FFFF0 at two grants 5 cycles apart -> rvalid one cycle after each grant; second value = first + 5.
- Write 0x48 then 0x69 to 0x3FFFF8 with cons_ready_i=1 -> cons_data_o shows 0x48 then 0x69, one cycle after each push; STATUS occupancy returns to 0.
- cons_ready_i=0, 9 CONSOLE writes with FIFO_DEPTH=8 -> 8 granted, 9th held with gnt=0, STATUS=0x40000008; raise cons_ready_i -> 9th granted the cycle after the first pop, bytes emerge in order.
- Write 0x00000001 to 0x3FFFFC -> done_o=1, pass_o=1, exit_code_o=0 next cycle; later write 0x0000000B -> no change.
- Write 0x0000000B with be=4'h3 -> ignored; same write with be=4'hF -> done_o=1, exit_code_o=5, pass_o=0.
- Assert rstn_i low in the cycle after a granted read, with FIFO holding 3 bytes -> data_rvalid_o=0, cons_valid_o=0, STATUS reads 0 after reset release.
